clk_freq_meter: RTL and testbench
=================================

// Module: clk_freq_meter
// PURPOSE
//  Receive-side companion to the clock_counter divider chain: measures a divided clock
//  (e.g. 1 kHz vending-machine tick) in fpga_clk cycles. Synchronises i_clk, detects
//  rising edges, counts cycles between them, flags out-of-tolerance/missing clocks.
//  Sits beside clk_cntr_top as a self-check for downstream FSM timing.
// PARAMETERS
//  from    100_000_000  fpga_clk frequency, Hz
//  to      1_000        expected i_clk frequency, Hz; localparam EXP = from/to
//  TOL     1_000        allowed deviation from EXP, fpga_clk cycles
//  CNT_W   32           counter/period width; must hold 2*EXP
//  LOCK_N  4            consecutive good periods for lock (CLK_MON_LOCK_EN only)
// PORTS
//  fpga_clk      in   1      system clock, all logic on rising edge
//  reset         in   1      synchronous, active-high
//  i_clk         in   1      measured clock, asynchronous to fpga_clk
//  en            in   1      1 = measure, 0 = idle
//  period        out  CNT_W  last measured period, fpga_clk cycles
//  period_valid  out  1      1-cycle pulse when period updates
//  too_fast      out  1      last period < EXP-TOL (held)
//  too_slow      out  1      last period > EXP+TOL (held)
//  timeout       out  1      no i_clk rise for 2*EXP cycles (sticky)
//  locked        out  1      only with CLK_MON_LOCK_EN
// BEHAVIOUR
//  - Reset: state IDLE, cnt=0, sync flops=0, all outputs 0.
//  - Sync: 2-FF synchroniser + 1 history flop; rise = s2 & ~s3. rise asserts 2-3
//    fpga_clk cycles after i_clk edge; constant latency, so period is unaffected.
//  - FSM IDLE: cnt=0; en=1 -> ARM next cycle.
//  - ARM: wait for rise; on rise -> MEASURE, cnt<=1. No output on arming rise.
//  - MEASURE: cnt+1 each cycle (cnt = cycles since last rise). On rise: period<=cnt,
//    period_valid=1 for one cycle, too_fast/too_slow recomputed from cnt,
//    timeout<=0, cnt<=1, stay MEASURE.
//  - Timeout: cnt==2*EXP with no rise that cycle -> timeout<=1, flags unchanged,
//    -> ARM, cnt<=0. Rise on same cycle as cnt==2*EXP: rise wins (valid measurement).
//  - en=0 in any state -> IDLE next cycle; cnt cleared; period held; too_fast,
//    too_slow, timeout cleared; no period_valid. Re-enable restarts from ARM.
//  - Flags held between updates; period_valid never asserted outside MEASURE.
//  - cnt never exceeds 2*EXP (no wrap).
//  - reset mid-measurement: all state and outputs to reset values next cycle.
// CONFIGURATION
//  CLK_MON_LOCK_EN defined: locked port + LOCK_N-saturating good-count. Good period
//    (no flag) increments; locked=1 once count reaches LOCK_N. Any bad period,
//    timeout, en=0 or reset clears count and locked the same update cycle.
//  Not defined: no locked port, no lock logic; all else identical.
// TESTING  (bench params: from=1000, to=10 -> EXP=100, TOL=2, timeout 200)
//  1 reset high 5 cycles, i_clk toggling -> all outputs 0, no period_valid.
//  2 en=1, i_clk period 100 -> first valid after 2nd rise, period=100, flags 0.
//  3 i_clk period 90 -> period=90, too_fast=1; then period 105 -> too_slow=1, too_fast=0.
//  4 i_clk stops after a rise -> timeout=1 exactly 200 cycles later, state ARM;
//    restart at period 100 -> timeout=0 on next period_valid, period=100.
//  5 en=0 at cnt=50 -> no period_valid, flags 0, period holds 100; en=1 -> re-arm,
//    first valid one full period after arming rise.
//  6 (CLK_MON_LOCK_EN) 4 periods of 100 -> locked=1 on 4th valid; one period 110 ->
//    locked=0 same cycle as its period_valid.

Source files
------------

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: measures the period of i_clk in fpga_clk cycles and flags fast/slow/missing clocks.
// Optional CLK_MON_LOCK_EN adds LOCK_N parameter, locked port and good-period counter.
module clk_freq_meter #(
  parameter int from  = 100_000_000,
  parameter int to    = 1_000,
  parameter int TOL   = 1_000,
  parameter int CNT_W = 32
`ifdef CLK_MON_LOCK_EN
  , parameter int LOCK_N = 4
`endif
) (
  input  logic             fpga_clk,
  input  logic             reset,
  input  logic             i_clk,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             too_fast,
  output logic             too_slow,
  output logic             timeout
`ifdef CLK_MON_LOCK_EN
  , output logic           locked
`endif
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  localparam int EXP = from / to;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(2 * EXP);
  localparam logic [CNT_W-1:0] LO  = CNT_W'(EXP - TOL);
  localparam logic [CNT_W-1:0] HI  = CNT_W'(EXP + TOL);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [2:0] sync_q, sync_d;
  logic valid_q, valid_d, fast_q, fast_d, slow_q, slow_d, tmo_q, tmo_d;
  logic rise, expire, meas;
  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-history flop
  assign sync_d = {sync_q[1:0], i_clk};
  assign rise   = sync_q[1] & ~sync_q[2];
  assign meas   = en && state_q == MEASURE && rise;
  assign expire = en && state_q == MEASURE && !rise && cnt_q == LIM;
  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sync_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      fast_q   <= 1'b0;
      slow_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      fast_q   <= fast_d;
      slow_q   <= slow_d;
      tmo_q    <= tmo_d;
    end
  end
  always_comb begin
    state_d = !en                ? IDLE :
              state_q == IDLE    ? ARM :
              state_q == ARM     ? (rise ? MEASURE : ARM) :
              expire             ? ARM : MEASURE;
    cnt_d   = (!en || state_q == IDLE || expire) ? '0 :
              rise                               ? CNT_W'(1) :
              state_q == MEASURE                 ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // A rise coinciding with cnt==LIM is a valid measurement, so expire excludes rise
  always_comb begin
    valid_d  = meas;
    period_d = meas ? cnt_q : period_q;
    fast_d   = !en ? 1'b0 : meas ? cnt_q < LO : fast_q;
    slow_d   = !en ? 1'b0 : meas ? cnt_q > HI : slow_q;
    tmo_d    = !en ? 1'b0 : meas ? 1'b0 : expire ? 1'b1 : tmo_q;
  end
  assign period       = period_q;
  assign period_valid = valid_q;
  assign too_fast     = fast_q;
  assign too_slow     = slow_q;
  assign timeout      = tmo_q;
`ifdef CLK_MON_LOCK_EN
  localparam int LW = $clog2(LOCK_N + 1);
  logic [LW-1:0] good_q, good_d;
  logic lock_q, lock_d, good;
  assign good = meas && cnt_q >= LO && cnt_q <= HI;
  always_comb begin
    good_d = (!en || expire || (meas && !good)) ? '0 :
             (good && good_q != LW'(LOCK_N))    ? good_q + LW'(1) : good_q;
    lock_d = good_d == LW'(LOCK_N);
  end
  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      good_q <= '0;
      lock_q <= 1'b0;
    end else begin
      good_q <= good_d;
      lock_q <= lock_d;
    end
  end
  assign locked = lock_q;
`endif
endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter: directed table-driven bench for clk_freq_meter (EXP=100, TOL=2, timeout 200).
module tb_clk_freq_meter;
  logic fpga_clk, reset, i_clk, en;
  logic [15:0] period;
  logic period_valid, too_fast, too_slow, timeout, locked;
  int checks, failures;
  typedef struct packed {logic [15:0] p; logic f; logic s; logic t; logic l;} obs_t;
  typedef struct {int per; logic [15:0] p; logic f; logic s;} vec_t;
  obs_t q[$];
  vec_t tbl[8];
  clk_freq_meter #(
    .from(1000), .to(10), .TOL(2), .CNT_W(16)
`ifdef CLK_MON_LOCK_EN
    , .LOCK_N(4)
`endif
  ) dut (
    .fpga_clk(fpga_clk), .reset(reset), .i_clk(i_clk), .en(en),
    .period(period), .period_valid(period_valid), .too_fast(too_fast),
    .too_slow(too_slow), .timeout(timeout)
`ifdef CLK_MON_LOCK_EN
    , .locked(locked)
`endif
  );
`ifndef CLK_MON_LOCK_EN
  assign locked = 1'b0;
`endif
  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;
  always @(negedge fpga_clk)
    if (period_valid) q.push_back({period, too_fast, too_slow, timeout, locked});
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge fpga_clk);
    #1;
  endtask
  task automatic edge_at(input int per);
    i_clk = 1'b1;
    cyc(per / 2);
    i_clk = 1'b0;
    cyc(per - per / 2);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic got;
    checks = 0;
    failures = 0;
    tbl[0] = '{100, 16'd100, 1'b0, 1'b0};
    tbl[1] = '{100, 16'd100, 1'b0, 1'b0};
    tbl[2] = '{90,  16'd90,  1'b1, 1'b0};
    tbl[3] = '{105, 16'd105, 1'b0, 1'b1};
    tbl[4] = '{98,  16'd98,  1'b0, 1'b0};
    tbl[5] = '{97,  16'd97,  1'b1, 1'b0};
    tbl[6] = '{102, 16'd102, 1'b0, 1'b0};
    tbl[7] = '{103, 16'd103, 1'b0, 1'b1};
    reset = 1'b1;
    en = 1'b1;
    i_clk = 1'b0;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      i_clk = ~i_clk;
      cyc(1);
      chk("rst_valid", period_valid, 0);
    end
    chk("rst_outs", {period, too_fast, too_slow, timeout, locked}, 0);
    en = 1'b0;
    i_clk = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    chk("rst_no_push", q.size(), 0);
    en = 1'b1;
    cyc(3);
    for (int i = 0; i < 8; i++) begin
      edge_at(tbl[i].per);
      if (i == 0) chk("arm_no_valid", q.size(), 0);
    end
    i_clk = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 10 && !got) begin
      @(negedge fpga_clk);
      n++;
      got = period_valid;
    end
    chk("final_valid", got, 1);
    n = 0;
    while (n < 300 && !timeout) begin
      @(negedge fpga_clk);
      n++;
      if (n == 5) i_clk = 1'b0;
    end
    chk("timeout_latency", n, 200);
    chk("timeout_flags_held", {too_fast, too_slow}, 2'b01);
    chk("table_count", q.size(), 8);
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      chk($sformatf("tbl%0d_period", i), q[i].p, tbl[i].p);
      chk($sformatf("tbl%0d_fast", i), q[i].f, tbl[i].f);
      chk($sformatf("tbl%0d_slow", i), q[i].s, tbl[i].s);
      chk($sformatf("tbl%0d_tmo", i), q[i].t, 0);
    end
    q.delete();
    cyc(1);
    edge_at(100);
    chk("rearm_no_valid", q.size(), 0);
    chk("timeout_sticky", timeout, 1);
    i_clk = 1'b1;
    cyc(50);
    i_clk = 1'b0;
    cyc(2);
    chk("restart_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("restart_period", q[0].p, 100);
      chk("restart_tmo_clr", q[0].t, 0);
    end
    en = 1'b0;
    cyc(5);
    i_clk = 1'b1;
    cyc(5);
    i_clk = 1'b0;
    cyc(10);
    chk("dis_no_valid", q.size(), 1);
    chk("dis_period_hold", period, 100);
    chk("dis_flags", {too_fast, too_slow, timeout}, 0);
    en = 1'b1;
    cyc(3);
    edge_at(100);
    chk("reen_arm_no_valid", q.size(), 1);
    edge_at(90);
    i_clk = 1'b1;
    cyc(6);
    i_clk = 1'b0;
    cyc(2);
    chk("reen_count", q.size(), 3);
    if (q.size() > 2) begin
      chk("reen_period", q[1].p, 100);
      chk("reen_fast_period", q[2].p, 90);
      chk("reen_fast_flag", q[2].f, 1);
    end
    chk("fast_live", too_fast, 1);
    en = 1'b0;
    cyc(2);
    chk("dis_fast_clr", too_fast, 0);
    chk("dis_period90", period, 90);
`ifdef CLK_MON_LOCK_EN
    q.delete();
    en = 1'b1;
    cyc(3);
    for (int i = 0; i < 5; i++) edge_at(100);
    edge_at(110);
    i_clk = 1'b1;
    cyc(6);
    i_clk = 1'b0;
    cyc(2);
    chk("lock_count", q.size(), 6);
    for (int i = 0; i < 6 && i < q.size(); i++)
      chk($sformatf("lock%0d", i), q[i].l, (i == 3 || i == 4) ? 1 : 0);
    chk("lock_live", locked, 0);
    en = 1'b0;
    cyc(2);
`endif
    en = 1'b1;
    cyc(3);
    edge_at(100);
    edge_at(90);
    i_clk = 1'b1;
    cyc(6);
    i_clk = 1'b0;
    cyc(20);
    chk("pre_reset_fast", too_fast, 1);
    reset = 1'b1;
    cyc(1);
    chk("mid_reset_outs", {period, period_valid, too_fast, too_slow, timeout, locked}, 0);
    reset = 1'b0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
